// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding / hazard unit:
//   state_t    - hazard controller states (RUN, LDUSE, MWAIT)
//   stage_t    - names for the bypass source stages, nearest first
//   SEL_RF     - fwd_sel value that selects the register file
//   LDCNT_W    - width of the remaining load-use bubble counter
//   CNT_W      - width of the stall/freeze statistics counter
//   sel_width  - forwarding select width for a given number of stages
// ---------------------------------------------------------------------------
package fwd_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_MWAIT = 2'd2
  } state_t;

  typedef enum int {
    STG_EXMEM = 0,
    STG_MEMWB = 1,
    STG_WB1   = 2
  } stage_t;

  localparam int SEL_RF  = 0;
  localparam int LDCNT_W = 3;
  localparam int CNT_W   = 16;

  // One code for the register file plus one code per bypass stage.
  function automatic int sel_width(input int nstages);
    return $clog2(nstages + 1);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// ---------------------------------------------------------------------------
// fwd_port_sel
// Forwarding source select for a single register read port.
//   rs            in   RW          source register of this port
//   stg_rd        in   NSTAGES*RW  destination of stage s at [s*RW +: RW]
//   stg_regwrite  in   NSTAGES     stage s writes the register file
//   sel           out  SW          0 = register file, s+1 = stage s
// ---------------------------------------------------------------------------
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int NSTAGES = 2,
  parameter int RW      = 5,
  parameter int SW      = 2
) (
  input  logic [RW-1:0]         rs,
  input  logic [NSTAGES*RW-1:0] stg_rd,
  input  logic [NSTAGES-1:0]    stg_regwrite,
  output logic [SW-1:0]         sel
);

  // Scan from the farthest stage towards the nearest so the nearest match
  // overwrites older ones. A zero rs never matches, which also keeps
  // register 0 (and any stage writing register 0) out of the bypass path.
  always_comb begin
    sel = SW'(SEL_RF);
    for (int s = NSTAGES - 1; s >= int'(STG_EXMEM); s--) begin
      if ((rs != '0) && stg_regwrite[s] && (stg_rd[s*RW +: RW] == rs)) begin
        sel = SW'(s + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Operand forwarding selects plus load-use / memory-wait pipeline control.
//   clk           in   1           rising-edge clock
//   rst_n         in   1           synchronous active-low reset
//   ex_rs         in   NPORTS*RW   EX instruction sources, port p at [p*RW +: RW]
//   id_rs         in   NPORTS*RW   ID instruction sources, same packing
//   stg_rd        in   NSTAGES*RW  destination of bypass stage s
//   stg_regwrite  in   NSTAGES     bypass stage s writes the register file
//   ex_memread    in   1           EX instruction is a load
//   ex_rd         in   RW          EX instruction destination
//   mem_req       in   1           MEM stage has an outstanding access
//   dmem_ready    in   1           data memory completes this cycle
//   fwd_sel       out  NPORTS*SW   per-port forwarding select
//   stall         out  1           hold PC and IF/ID
//   bubble        out  1           insert NOP into ID/EX
//   freeze        out  1           hold every pipeline register
//   stall_cnt     out  16          saturating count of stall|freeze cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int NSTAGES  = 2,
  parameter int RW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NPORTS*RW-1:0]                 ex_rs,
  input  logic [NPORTS*RW-1:0]                 id_rs,
  input  logic [NSTAGES*RW-1:0]                stg_rd,
  input  logic [NSTAGES-1:0]                   stg_regwrite,
  input  logic                                 ex_memread,
  input  logic [RW-1:0]                        ex_rd,
  input  logic                                 mem_req,
  input  logic                                 dmem_ready,
  output logic [NPORTS*sel_width(NSTAGES)-1:0] fwd_sel,
  output logic                                 stall,
  output logic                                 bubble,
  output logic                                 freeze,
  output logic [CNT_W-1:0]                     stall_cnt
);

  localparam int SW = sel_width(NSTAGES);

  state_t               state_q, state_d;
  state_t               resume_q, resume_d;
  state_t               eff_state;
  logic [LDCNT_W-1:0]   cnt_q, cnt_d;
  logic                 hazard;
  logic                 memwait;
  logic                 stall_c, bubble_c, freeze_c;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    fwd_port_sel #(
      .NSTAGES (NSTAGES),
      .RW      (RW),
      .SW      (SW)
    ) u_sel (
      .rs           (ex_rs[p*RW +: RW]),
      .stg_rd       (stg_rd),
      .stg_regwrite (stg_regwrite),
      .sel          (fwd_sel[p*SW +: SW])
    );
  end

  always_comb begin
    hazard = 1'b0;
    if (ex_memread && (ex_rd != '0)) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (id_rs[p*RW +: RW] == ex_rd) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign memwait = mem_req && !dmem_ready;

  // On the cycle memory becomes ready MWAIT behaves exactly like the state it
  // interrupted, so hazards (or the held load-use bubbles) take effect in
  // that same cycle without an extra dead cycle.
  always_comb begin
    state_d   = state_q;
    resume_d  = resume_q;
    cnt_d     = cnt_q;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    freeze_c  = 1'b0;
    eff_state = state_q;

    if (state_q == ST_MWAIT) begin
      if (dmem_ready) begin
        eff_state = resume_q;
      end else begin
        freeze_c = 1'b1;
      end
    end

    case (eff_state)
      ST_RUN: begin
        state_d = ST_RUN;
        if (memwait) begin
          freeze_c = 1'b1;
          state_d  = ST_MWAIT;
          resume_d = ST_RUN;
        end else if (hazard) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_LDUSE;
            cnt_d   = LDCNT_W'(LOAD_LAT - 1);
          end
        end
      end
      ST_LDUSE: begin
        // The remaining count is held untouched across a memory wait.
        if (memwait) begin
          freeze_c = 1'b1;
          state_d  = ST_MWAIT;
          resume_d = ST_LDUSE;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          cnt_d    = cnt_q - LDCNT_W'(1);
          state_d  = (cnt_q == LDCNT_W'(1)) ? ST_RUN : ST_LDUSE;
        end
      end
      default: begin
        state_d = ST_MWAIT;
      end
    endcase
  end

  assign stall  = rst_n && stall_c;
  assign bubble = rst_n && bubble_c;
  assign freeze = rst_n && freeze_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      resume_q  <= ST_RUN;
      cnt_q     <= '0;
      stall_cnt <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      cnt_q    <= cnt_d;
      if ((stall || freeze) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Drives two instances (LOAD_LAT=2 and LOAD_LAT=3) with shared inputs and
// checks both against a cycle-level behavioural model through a scoreboard.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int NP = 2;
  localparam int NS = 2;
  localparam int RW = 5;
  localparam int SW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*RW-1:0]  ex_rs, id_rs;
  logic [NS*RW-1:0]  stg_rd;
  logic [NS-1:0]     stg_regwrite;
  logic              ex_memread;
  logic [RW-1:0]     ex_rd;
  logic              mem_req, dmem_ready;

  logic [NP*SW-1:0]  fwd_sel_a, fwd_sel_b;
  logic              stall_a, bubble_a, freeze_a;
  logic              stall_b, bubble_b, freeze_b;
  logic [15:0]       stall_cnt_a, stall_cnt_b;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NPORTS(NP), .NSTAGES(NS), .RW(RW), .LOAD_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .id_rs(id_rs), .stg_rd(stg_rd),
    .stg_regwrite(stg_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .fwd_sel(fwd_sel_a),
    .stall(stall_a), .bubble(bubble_a), .freeze(freeze_a), .stall_cnt(stall_cnt_a)
  );

  fwd_hazard_unit #(.NPORTS(NP), .NSTAGES(NS), .RW(RW), .LOAD_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .id_rs(id_rs), .stg_rd(stg_rd),
    .stg_regwrite(stg_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .fwd_sel(fwd_sel_b),
    .stall(stall_b), .bubble(bubble_b), .freeze(freeze_b), .stall_cnt(stall_cnt_b)
  );

  typedef struct {
    string       tag;
    logic [3:0]  fsel;
    logic [1:0]  st;
    logic [1:0]  bb;
    logic [1:0]  fz;
    logic        chk_cnt;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   lat[2];
  int   rem[2];
  bit   inwait[2];
  int   mcnt[2];
  bit   cnt_known = 1'b0;

  // Nearest writing stage with a matching non-zero destination wins.
  function automatic logic [1:0] ref_sel(input logic [4:0] rs, input logic [9:0] rd,
                                         input logic [1:0] rw);
    if (rs == 5'd0) return 2'd0;
    for (int s = 0; s < NS; s++) begin
      if (rw[s] && (rd[s*RW +: RW] == rs)) return 2'(s + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic [4:0] rnd_idx();
    return 5'($urandom_range(0, 3));
  endfunction

  task automatic cmp(input string tag, input string name, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s got %0h want %0h", tag, name, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.tag, "fwd_sel_a", 16'(fwd_sel_a), 16'(e.fsel));
    cmp(e.tag, "fwd_sel_b", 16'(fwd_sel_b), 16'(e.fsel));
    cmp(e.tag, "stall_a",   16'(stall_a),   16'(e.st[0]));
    cmp(e.tag, "bubble_a",  16'(bubble_a),  16'(e.bb[0]));
    cmp(e.tag, "freeze_a",  16'(freeze_a),  16'(e.fz[0]));
    cmp(e.tag, "stall_b",   16'(stall_b),   16'(e.st[1]));
    cmp(e.tag, "bubble_b",  16'(bubble_b),  16'(e.bb[1]));
    cmp(e.tag, "freeze_b",  16'(freeze_b),  16'(e.fz[1]));
    if (e.chk_cnt) begin
      cmp(e.tag, "stall_cnt_a", stall_cnt_a, e.cnt0);
      cmp(e.tag, "stall_cnt_b", stall_cnt_b, e.cnt1);
    end
  endtask

  // Monitor: outputs are valid every cycle, so compare one entry per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) checkOutput(sb.pop_front());
  end

  // Drive one cycle of inputs and push the model's view of that cycle.
  // rem counts load-use bubbles still owed after the current cycle; inwait
  // means a memory wait is pending and everything is frozen until ready.
  task automatic applyStimulus(input logic r, input logic [9:0] exrs, input logic [9:0] idrs,
                               input logic [9:0] srd, input logic [1:0] srw, input logic mr,
                               input logic [4:0] rd, input logic mq, input logic dr,
                               input string tag);
    exp_t e;
    bit   haz, mw;
    @(posedge clk);
    #1;
    rst_n = r; ex_rs = exrs; id_rs = idrs; stg_rd = srd; stg_regwrite = srw;
    ex_memread = mr; ex_rd = rd; mem_req = mq; dmem_ready = dr;

    e.tag     = tag;
    e.fsel    = {ref_sel(exrs[9:5], srd, srw), ref_sel(exrs[4:0], srd, srw)};
    e.st      = 2'b00;
    e.bb      = 2'b00;
    e.fz      = 2'b00;
    e.chk_cnt = cnt_known;
    e.cnt0    = 16'(mcnt[0]);
    e.cnt1    = 16'(mcnt[1]);
    haz = mr && (rd != 5'd0) && ((idrs[4:0] == rd) || (idrs[9:5] == rd));
    mw  = mq && !dr;

    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        rem[i] = 0; inwait[i] = 1'b0; mcnt[i] = 0;
      end else begin
        if (inwait[i] && !dr) begin
          e.fz[i] = 1'b1;
        end else begin
          inwait[i] = 1'b0;
          if (mw) begin
            e.fz[i] = 1'b1;
            inwait[i] = 1'b1;
          end else if (rem[i] > 0) begin
            e.st[i] = 1'b1; e.bb[i] = 1'b1;
            rem[i]--;
          end else if (haz) begin
            e.st[i] = 1'b1; e.bb[i] = 1'b1;
            rem[i] = lat[i] - 1;
          end
        end
        if ((e.st[i] || e.fz[i]) && (mcnt[i] < 65535)) mcnt[i]++;
      end
    end
    if (!r) cnt_known = 1'b1;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    logic [9:0] exrs, idrs, srd;
    rst_n = 1'b0; ex_rs = '0; id_rs = '0; stg_rd = '0; stg_regwrite = '0;
    ex_memread = 1'b0; ex_rd = '0; mem_req = 1'b0; dmem_ready = 1'b1;
    lat[0] = 2; lat[1] = 3;
    rem = '{0, 0}; inwait = '{1'b0, 1'b0}; mcnt = '{0, 0};

    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, "reset");
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, "reset");
    idle(1, "post_reset");

    // Both stages write r3, both ports read r3: nearest stage for both.
    applyStimulus(1'b1, {5'd3, 5'd3}, '0, {5'd3, 5'd3}, 2'b11, 1'b0, '0, 1'b0, 1'b1, "near_wins");
    // Stage 0 writes r0, port 0 reads r0: never forwarded.
    applyStimulus(1'b1, {5'd4, 5'd0}, '0, {5'd4, 5'd0}, 2'b11, 1'b0, '0, 1'b0, 1'b1, "reg0");
    applyStimulus(1'b1, {5'd6, 5'd6}, '0, {5'd6, 5'd2}, 2'b10, 1'b0, '0, 1'b0, 1'b1, "far_only");

    // Load-use on port 1.
    applyStimulus(1'b1, '0, {5'd7, 5'd1}, '0, '0, 1'b1, 5'd7, 1'b0, 1'b1, "lduse");
    idle(4, "lduse_tail");

    // Three cycles of memory wait, then ready.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, "mwait");
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1, "mready");
    idle(2, "mwait_tail");

    // Memory wait interrupting a load-use window.
    applyStimulus(1'b1, '0, {5'd2, 5'd9}, '0, '0, 1'b1, 5'd9, 1'b0, 1'b1, "ld_mw");
    idle(1, "ld_mw");
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, "ld_mw_wait");
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b1, "ld_mw_ready");
    idle(3, "ld_mw_tail");

    // Reset in the middle of a load-use window.
    applyStimulus(1'b1, '0, {5'd5, 5'd5}, '0, '0, 1'b1, 5'd5, 1'b0, 1'b1, "ld_rst");
    idle(1, "ld_rst");
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, "ld_rst_assert");
    idle(3, "ld_rst_after");

    for (int k = 0; k < 1500; k++) begin
      exrs = {rnd_idx(), rnd_idx()};
      idrs = {rnd_idx(), rnd_idx()};
      srd  = {rnd_idx(), rnd_idx()};
      applyStimulus(($urandom_range(0, 63) != 0), exrs, idrs, srd, 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0), rnd_idx(), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), "random");
    end

    // Long freeze to drive the statistics counter into saturation.
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1, "sat_reset");
    for (int k = 0; k < 65540; k++) applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, "sat");
    applyStimulus(1'b1, '0, {5'd8, 5'd8}, '0, '0, 1'b1, 5'd8, 1'b1, 1'b1, "sat_ld");
    idle(4, "sat_tail");

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain entries_left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
